// File: rtl/shift_deserializer_if.sv
// Bus bundle for shift_deserializer: the serial input side, the parallel
// output side, the frame bit-order select and the status flags.
// When SHIFT_DESERIALIZER_PARITY_EN is defined the bundle also carries parity_err.
//
// Handshake rule for both sides: a transfer happens on a rising edge where
// valid and ready are both 1. A producer holds its data steady until that
// edge. A consumer may change ready at any time. Neither side waits on the
// other side's valid/ready before asserting its own, so no combinational loop
// can form.
interface shift_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             s_din;
    logic             s_valid;
    logic             s_ready;
    logic             lsb_first;
    logic [WIDTH-1:0] p_dout;
    logic             p_valid;
    logic             p_ready;
    logic             overrun;
    logic             busy;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    logic             parity_err;

    modport master (
        output s_din, s_valid, lsb_first, p_ready,
        input  s_ready, p_dout, p_valid, overrun, busy, parity_err
    );

    modport slave (
        input  s_din, s_valid, lsb_first, p_ready,
        output s_ready, p_dout, p_valid, overrun, busy, parity_err
    );
`else
    modport master (
        output s_din, s_valid, lsb_first, p_ready,
        input  s_ready, p_dout, p_valid, overrun, busy
    );

    modport slave (
        input  s_din, s_valid, lsb_first, p_ready,
        output s_ready, p_dout, p_valid, overrun, busy
    );
`endif
endinterface

// File: rtl/shift_deserializer.sv
// shift_deserializer: collects WIDTH serial bits into one parallel word.
// The bit order (MSB first or LSB first) is latched at the start of each frame.
// The finished word is held until the consumer accepts it. A bit that arrives
// while a held word is blocked is dropped, and the sticky overrun flag is set.
// When SHIFT_DESERIALIZER_PARITY_EN is defined, an even-parity bit follows the
// data bits and its check result appears on parity_err.
// dbg_state exposes the FSM state so that it can be observed.
module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    shift_deserializer_if.slave bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overrun_q, overrun_d;
    logic             lsb_q, lsb_d;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    logic             s_ready_c;
    logic             busy_c;
    logic             xfer;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;

    // Accept/busy flags. Reset forces the idle view at once, without waiting for a clock edge.
    always_comb begin
        s_ready_c = 1'b1;
        busy_c    = 1'b0;
        if (!rst) begin
            if (state_q == ST_HOLD) begin
                s_ready_c = bus.p_ready;
            end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            busy_c = (state_q == ST_SHIFT) || (state_q == ST_PAR);
`else
            busy_c = (state_q == ST_SHIFT);
`endif
        end
    end

    assign xfer       = bus.s_valid & s_ready_c;
    assign shifted    = lsb_q ? {bus.s_din, shreg_q[WIDTH-1:1]}
                              : {shreg_q[WIDTH-2:0], bus.s_din};
    assign first_word = bus.lsb_first ? {bus.s_din, {(WIDTH-1){1'b0}}}
                                      : {{(WIDTH-1){1'b0}}, bus.s_din};

    // Next-state logic: load the first bit, shift each new bit in, and present the word when the frame is done.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        overrun_d = overrun_q;
        lsb_d     = lsb_q;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    shreg_d = first_word;
                    lsb_d   = bus.lsb_first;
                    count_d = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (xfer) begin
                    shreg_d = shifted;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
`ifdef SHIFT_DESERIALIZER_PARITY_EN
                        state_d = ST_PAR;
`else
                        dout_d  = shifted;
                        state_d = ST_HOLD;
`endif
                    end
                end
            end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            ST_PAR: begin
                if (xfer) begin
                    parity_err_d = (^shreg_q) ^ bus.s_din;
                    dout_d       = shreg_q;
                    state_d      = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                if (bus.p_ready) begin
                    if (bus.s_valid) begin
                        // The new frame starts on the same edge that the word is accepted.
                        shreg_d = first_word;
                        lsb_d   = bus.lsb_first;
                        count_d = CW'(1);
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.s_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            shreg_q   <= '0;
            dout_q    <= '0;
            overrun_q <= 1'b0;
            lsb_q     <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            overrun_q <= overrun_d;
            lsb_q     <= lsb_d;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.busy    = busy_c;
    assign bus.p_valid = (state_q == ST_HOLD);
    assign bus.p_dout  = dout_q;
    assign bus.overrun = overrun_q;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// Testbench for shift_deserializer (WIDTH=4).
// The reference model is kept at the frame level: it collects accepted bits in
// a queue and builds each word arithmetically. Each expected word goes into
// exp_q, and a separate monitor compares and pops entries on output handshakes.
module tb_shift_deserializer;
    localparam int WIDTH = 4;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clk;
    logic rst;
    logic [1:0] dbg_state;

    shift_deserializer_if #(.WIDTH(WIDTH)) ifc ();

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc),
        .dbg_state (dbg_state)
    );

    // Clock and timeout guard
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    int checks = 0;
    int errors = 0;

    // Scoreboard and reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_perr_q[$];
    logic             m_bits[$];
    logic             m_lsb;
    logic             m_hold;
    logic             m_overrun;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_bits.delete();
        m_hold = 1'b0;
        m_overrun = 1'b0;
        m_lsb = 1'b0;
        exp_q.delete();
        exp_perr_q.delete();
    endtask

    // Apply the rules for one edge, given the inputs presented during that cycle
    task automatic model_step(input logic din, input logic valid, input logic lsb, input logic pready);
        logic acc;
        logic [WIDTH-1:0] word;
        logic par;
        acc = valid && (!m_hold || pready);
        if (m_hold && pready) m_hold = 1'b0;
        else if (m_hold && valid) m_overrun = 1'b1;
        if (acc) begin
            if (m_bits.size() == 0) m_lsb = lsb;
            m_bits.push_back(din);
            if (m_bits.size() == FRAME) begin
                word = '0;
                par = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (m_lsb) word[i] = m_bits[i];
                    else word[WIDTH-1-i] = m_bits[i];
                end
                for (int i = 0; i < FRAME; i++) par ^= m_bits[i];
                exp_q.push_back(word);
                exp_perr_q.push_back(par);
                m_hold = 1'b1;
                m_bits.delete();
            end
        end
    endtask

    // Driver: present inputs for one cycle, check the status outputs, then advance the model
    task automatic cycle(input logic din, input logic valid, input logic lsb, input logic pready);
        @(posedge clk);
        #1;
        ifc.s_din = din;
        ifc.s_valid = valid;
        ifc.lsb_first = lsb;
        ifc.p_ready = pready;
        @(negedge clk);
        check("s_ready", ifc.s_ready, (!m_hold || pready));
        check("p_valid", ifc.p_valid, m_hold);
        check("overrun", ifc.overrun, m_overrun);
        check("busy", ifc.busy, m_bits.size() != 0);
        model_step(din, valid, lsb, pready);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ifc.s_valid = 1'b1;
        ifc.s_din = 1'($urandom_range(0, 1));
        ifc.lsb_first = 1'($urandom_range(0, 1));
        ifc.p_ready = 1'($urandom_range(0, 1));
        model_clear();
        @(negedge clk);
        check("rst_s_ready", ifc.s_ready, 1);
        check("rst_busy", ifc.busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.s_valid = 1'b0;
        ifc.p_ready = 1'b0;
        @(negedge clk);
        check("post_rst_p_dout", ifc.p_dout, 0);
        check("post_rst_p_valid", ifc.p_valid, 0);
        check("post_rst_overrun", ifc.overrun, 0);
        check("post_rst_busy", ifc.busy, 0);
        check("post_rst_s_ready", ifc.s_ready, 1);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        check("post_rst_parity_err", ifc.parity_err, 0);
`endif
    endtask

    // Send one frame; seq[WIDTH-1] goes first. The first bit may coincide with a handshake.
    task automatic send_frame(input logic [WIDTH-1:0] seq, input logic lsb, input logic first_pready);
        for (int i = 0; i < WIDTH; i++) begin
            cycle(seq[WIDTH-1-i], 1'b1, lsb, (i == 0) ? first_pready : 1'b0);
        end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        cycle(^seq, 1'b1, lsb, 1'b0);
`endif
    endtask

    // Monitor: while a word is presented, compare it with the head of the scoreboard; pop the entry on handshake
    always @(negedge clk) begin
        if (rst === 1'b0 && ifc.p_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL p_word: got %0h expected no word presented at %0t", ifc.p_dout, $time);
            end else begin
                check("p_dout", ifc.p_dout, exp_q[0]);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
                check("parity_err", ifc.parity_err, exp_perr_q[0]);
`endif
                if (ifc.p_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    void'(exp_perr_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifc.s_din = 1'b0;
        ifc.s_valid = 1'b0;
        ifc.lsb_first = 1'b0;
        ifc.p_ready = 1'b0;
        model_clear();
        do_reset();

        // MSB first: bits 1,1,0,1 give 1101
        send_frame(4'b1101, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("msb_first_word", ifc.p_dout, 4'b1101);

        // Blocked output: 5 bits are dropped, the word is held, overrun becomes set
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("hold_word", ifc.p_dout, 4'b1101);
        check("hold_overrun", ifc.overrun, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("overrun_sticky", ifc.overrun, 1);
        do_reset();

        // LSB first: bits 1,0,1,1 give 1101
        send_frame(4'b1011, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lsb_first_word", ifc.p_dout, 4'b1101);

        // Back to back: the handshake edge also carries the first bit of the next frame
        send_frame(4'b0110, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_word", ifc.p_dout, 4'b0110);
        check("b2b_overrun", ifc.overrun, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a frame, then send a clean frame
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        send_frame(4'b0110, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("after_rst_word", ifc.p_dout, 4'b0110);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
        // Parity: a correct parity bit and then a wrong one
        for (int i = 0; i < WIDTH; i++) cycle(1'(4'b1101 >> (WIDTH-1-i)), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("par_ok_err", ifc.parity_err, 0);
        check("par_ok_word", ifc.p_dout, 4'b1101);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < WIDTH; i++) cycle(1'(4'b1101 >> (WIDTH-1-i)), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("par_bad_err", ifc.parity_err, 1);
        check("par_bad_word", ifc.p_dout, 4'b1101);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Random traffic with occasional resets
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
            end
        end

        // Drain: accept any word still held, with a cycle limit
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
